// File: rtl/tri_pkg.sv
// rtl/tri_pkg.sv - vertex field layout, coefficient widths and FSM encoding for tri_setup
package tri_pkg;

   localparam int DW_VERTEX = 64;
   localparam int X_LSB     = 0;
   localparam int Y_LSB     = 16;
   localparam int ATTR_LSB  = 32;
   localparam int COORD_W   = 16;
   localparam int ATTR_W    = 32;

   localparam int AB_W   = 17;
   localparam int C_W    = 33;
   localparam int AREA_W = 35;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_E0   = 3'd1,
      S_E1   = 3'd2,
      S_E2   = 3'd3,
      S_AREA = 3'd4,
      S_BBOX = 3'd5,
      S_OUT  = 3'd6
   } tri_state_t;

   function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a < b) ? a : b;
      return (m < c) ? m : c;
   endfunction

   function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b,
                                               input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/tri_edge_coef.sv
// rtl/tri_edge_coef.sv - combinational edge-function coefficients A/B/C for edge a->b
module tri_edge_coef
   import tri_pkg::*;
(
   input  logic [COORD_W-1:0]    xa,
   input  logic [COORD_W-1:0]    ya,
   input  logic [COORD_W-1:0]    xb,
   input  logic [COORD_W-1:0]    yb,
   output logic signed [AB_W-1:0] a,
   output logic signed [AB_W-1:0] b,
   output logic signed [C_W-1:0]  c
);

   logic [2*COORD_W-1:0] p_ab;
   logic [2*COORD_W-1:0] p_ba;

   assign p_ab = (2*COORD_W)'(xa) * (2*COORD_W)'(yb);
   assign p_ba = (2*COORD_W)'(xb) * (2*COORD_W)'(ya);

   // One extra bit on every difference keeps the signed result exact
   assign a = $signed({1'b0, ya} - {1'b0, yb});
   assign b = $signed({1'b0, xb} - {1'b0, xa});
   assign c = $signed({1'b0, p_ab} - {1'b0, p_ba});

endmodule

// File: rtl/tri_setup.sv
// rtl/tri_setup.sv - triangle setup engine; TRI_SETUP_CULL_EN selects back-face drop instead of winding flip
module tri_setup
   import tri_pkg::*;
#(
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480
) (
   input  logic                    CLK,
   input  logic                    rst_n,
   input  logic                    tri_start,
   input  logic [DW_VERTEX-1:0]    tri_v0,
   input  logic [DW_VERTEX-1:0]    tri_v1,
   input  logic [DW_VERTEX-1:0]    tri_v2,
   output logic                    vt_ready,
   output logic                    busy,
   output logic                    rs_valid,
   input  logic                    rs_ready,
   output logic signed [AB_W-1:0]  rs_a0,
   output logic signed [AB_W-1:0]  rs_a1,
   output logic signed [AB_W-1:0]  rs_a2,
   output logic signed [AB_W-1:0]  rs_b0,
   output logic signed [AB_W-1:0]  rs_b1,
   output logic signed [AB_W-1:0]  rs_b2,
   output logic signed [C_W-1:0]   rs_c0,
   output logic signed [C_W-1:0]   rs_c1,
   output logic signed [C_W-1:0]   rs_c2,
   output logic signed [AREA_W-1:0] rs_area2,
   output logic [COORD_W-1:0]      rs_xmin,
   output logic [COORD_W-1:0]      rs_xmax,
   output logic [COORD_W-1:0]      rs_ymin,
   output logic [COORD_W-1:0]      rs_ymax,
   output logic [ATTR_W-1:0]       rs_attr0,
   output logic [ATTR_W-1:0]       rs_attr1,
   output logic [ATTR_W-1:0]       rs_attr2,
   output logic [15:0]             drop_cnt
);

   localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
   localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

   tri_state_t state, state_nxt;

   logic [DW_VERTEX-1:0]    v_q [3];
   logic [DW_VERTEX-1:0]    va, vb;
   logic signed [AB_W-1:0]  e_a, e_b;
   logic signed [C_W-1:0]   e_c;
   logic signed [AB_W-1:0]  a_q [3];
   logic signed [AB_W-1:0]  b_q [3];
   logic signed [C_W-1:0]   c_q [3];
   logic signed [AREA_W-1:0] area_sum, area_q;
   logic [COORD_W-1:0]      xmin_c, xmax_c, ymin_c, ymax_c;
   logic [COORD_W-1:0]      xmin_q, xmax_q, ymin_q, ymax_q;
   logic                    area_zero, area_neg, area_flip, cull_drop, offscreen;
   logic                    drop_now, done_now, vt_q;
   logic [15:0]             drop_q;

   always_comb begin
      va = v_q[0];
      vb = v_q[1];
      case (state)
         S_E1: begin va = v_q[1]; vb = v_q[2]; end
         S_E2: begin va = v_q[2]; vb = v_q[0]; end
         default: ;
      endcase
   end

   tri_edge_coef u_edge (
      .xa (va[X_LSB +: COORD_W]),
      .ya (va[Y_LSB +: COORD_W]),
      .xb (vb[X_LSB +: COORD_W]),
      .yb (vb[Y_LSB +: COORD_W]),
      .a  (e_a),
      .b  (e_b),
      .c  (e_c)
   );

   assign area_sum  = {{2{c_q[0][C_W-1]}}, c_q[0]}
                    + {{2{c_q[1][C_W-1]}}, c_q[1]}
                    + {{2{c_q[2][C_W-1]}}, c_q[2]};
   assign area_zero = (area_sum == '0);
   assign area_neg  = area_sum[AREA_W-1];

`ifdef TRI_SETUP_CULL_EN
   assign area_flip = 1'b0;
   assign cull_drop = area_neg;
`else
   assign area_flip = area_neg;
   assign cull_drop = 1'b0;
`endif

   assign xmin_c = min3(v_q[0][X_LSB +: COORD_W], v_q[1][X_LSB +: COORD_W], v_q[2][X_LSB +: COORD_W]);
   assign xmax_c = max3(v_q[0][X_LSB +: COORD_W], v_q[1][X_LSB +: COORD_W], v_q[2][X_LSB +: COORD_W]);
   assign ymin_c = min3(v_q[0][Y_LSB +: COORD_W], v_q[1][Y_LSB +: COORD_W], v_q[2][Y_LSB +: COORD_W]);
   assign ymax_c = max3(v_q[0][Y_LSB +: COORD_W], v_q[1][Y_LSB +: COORD_W], v_q[2][Y_LSB +: COORD_W]);
   assign offscreen = (xmin_c > X_LAST) || (ymin_c > Y_LAST);

   always_comb begin
      state_nxt = state;
      drop_now  = 1'b0;
      done_now  = 1'b0;
      case (state)
         S_IDLE: if (tri_start) state_nxt = S_E0;
         S_E0:   state_nxt = S_E1;
         S_E1:   state_nxt = S_E2;
         S_E2:   state_nxt = S_AREA;
         S_AREA: begin
            if (area_zero || cull_drop) begin
               drop_now  = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_BBOX;
            end
         end
         S_BBOX: begin
            if (offscreen) begin
               drop_now  = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               state_nxt = S_OUT;
            end
         end
         S_OUT: begin
            if (rs_ready) begin
               done_now  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         vt_q   <= 1'b0;
         drop_q <= '0;
      end else begin
         state <= state_nxt;
         vt_q  <= drop_now || done_now;
         if (drop_now && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            v_q[i] <= '0;
            a_q[i] <= '0;
            b_q[i] <= '0;
            c_q[i] <= '0;
         end
         area_q <= '0;
         xmin_q <= '0;
         xmax_q <= '0;
         ymin_q <= '0;
         ymax_q <= '0;
      end else begin
         if (state == S_IDLE && tri_start) begin
            v_q[0] <= tri_v0;
            v_q[1] <= tri_v1;
            v_q[2] <= tri_v2;
         end
         case (state)
            S_E0: begin a_q[0] <= e_a; b_q[0] <= e_b; c_q[0] <= e_c; end
            S_E1: begin a_q[1] <= e_a; b_q[1] <= e_b; c_q[1] <= e_c; end
            S_E2: begin a_q[2] <= e_a; b_q[2] <= e_b; c_q[2] <= e_c; end
            S_AREA: begin
               // Flipping the winding keeps every emitted triangle's area positive
               area_q <= area_flip ? -area_sum : area_sum;
               if (area_flip) begin
                  for (int i = 0; i < 3; i++) begin
                     a_q[i] <= -a_q[i];
                     b_q[i] <= -b_q[i];
                     c_q[i] <= -c_q[i];
                  end
               end
            end
            S_BBOX: begin
               xmin_q <= xmin_c;
               ymin_q <= ymin_c;
               xmax_q <= (xmax_c > X_LAST) ? X_LAST : xmax_c;
               ymax_q <= (ymax_c > Y_LAST) ? Y_LAST : ymax_c;
            end
            default: ;
         endcase
      end
   end

   assign vt_ready = vt_q;
   assign busy     = (state != S_IDLE) || vt_q;
   assign rs_valid = (state == S_OUT);
   assign drop_cnt = drop_q;

   assign rs_a0 = a_q[0];
   assign rs_a1 = a_q[1];
   assign rs_a2 = a_q[2];
   assign rs_b0 = b_q[0];
   assign rs_b1 = b_q[1];
   assign rs_b2 = b_q[2];
   assign rs_c0 = c_q[0];
   assign rs_c1 = c_q[1];
   assign rs_c2 = c_q[2];
   assign rs_area2 = area_q;
   assign rs_xmin  = xmin_q;
   assign rs_xmax  = xmax_q;
   assign rs_ymin  = ymin_q;
   assign rs_ymax  = ymax_q;
   assign rs_attr0 = v_q[0][ATTR_LSB +: ATTR_W];
   assign rs_attr1 = v_q[1][ATTR_LSB +: ATTR_W];
   assign rs_attr2 = v_q[2][ATTR_LSB +: ATTR_W];

endmodule

// File: tb/tb_tri_setup.sv
// tb/tb_tri_setup.sv - self-checking bench for tri_setup (table vectors, corner sequences, random vs. model)
module tb_tri_setup;

   logic               CLK = 1'b0;
   logic               rst_n;
   logic               tri_start;
   logic [63:0]        tri_v0, tri_v1, tri_v2;
   logic               vt_ready, busy, rs_valid, rs_ready;
   logic signed [16:0] rs_a0, rs_a1, rs_a2, rs_b0, rs_b1, rs_b2;
   logic signed [32:0] rs_c0, rs_c1, rs_c2;
   logic signed [34:0] rs_area2;
   logic [15:0]        rs_xmin, rs_xmax, rs_ymin, rs_ymax;
   logic [31:0]        rs_attr0, rs_attr1, rs_attr2;
   logic [15:0]        drop_cnt;

   always #5 CLK = ~CLK;

   tri_setup dut (
      .CLK(CLK), .rst_n(rst_n), .tri_start(tri_start),
      .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2),
      .vt_ready(vt_ready), .busy(busy), .rs_valid(rs_valid), .rs_ready(rs_ready),
      .rs_a0(rs_a0), .rs_a1(rs_a1), .rs_a2(rs_a2),
      .rs_b0(rs_b0), .rs_b1(rs_b1), .rs_b2(rs_b2),
      .rs_c0(rs_c0), .rs_c1(rs_c1), .rs_c2(rs_c2),
      .rs_area2(rs_area2),
      .rs_xmin(rs_xmin), .rs_xmax(rs_xmax), .rs_ymin(rs_ymin), .rs_ymax(rs_ymax),
      .rs_attr0(rs_attr0), .rs_attr1(rs_attr1), .rs_attr2(rs_attr2),
      .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic [63:0] v0, v1, v2;
      bit          drop;
      int          lat;
      longint      a0, a1, a2, b0, b1, b2, c0, c1, c2, area;
      longint      xmin, xmax, ymin, ymax;
   } vec_t;

   int   n_vec = 0;
   int   n_fail = 0;
   int   exp_drops = 0;
   vec_t tbl[$];

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [63:0] vtx(input int x, input int y, input logic [31:0] attr);
      return {attr, y[15:0], x[15:0]};
   endfunction

   function automatic vec_t mkv(input logic [63:0] v0, v1, v2, input bit drop, input int lat,
                                input longint a0, a1, a2, b0, b1, b2, c0, c1, c2, area,
                                input longint xmin, xmax, ymin, ymax);
      vec_t r;
      r.v0 = v0; r.v1 = v1; r.v2 = v2; r.drop = drop; r.lat = lat;
      r.a0 = a0; r.a1 = a1; r.a2 = a2; r.b0 = b0; r.b1 = b1; r.b2 = b2;
      r.c0 = c0; r.c1 = c1; r.c2 = c2; r.area = area;
      r.xmin = xmin; r.xmax = xmax; r.ymin = ymin; r.ymax = ymax;
      return r;
   endfunction

   // Reference model: plain integer arithmetic straight from the edge-function definitions
   function automatic vec_t model(input logic [63:0] v0, v1, v2);
      vec_t   r;
      longint x[3], y[3], a[3], b[3], c[3], ar, s;
      x[0] = longint'(v0[15:0]); y[0] = longint'(v0[31:16]);
      x[1] = longint'(v1[15:0]); y[1] = longint'(v1[31:16]);
      x[2] = longint'(v2[15:0]); y[2] = longint'(v2[31:16]);
      for (int i = 0; i < 3; i++) begin
         int j = (i + 1) % 3;
         a[i] = y[i] - y[j];
         b[i] = x[j] - x[i];
         c[i] = x[i] * y[j] - x[j] * y[i];
      end
      ar = c[0] + c[1] + c[2];
      s  = 1;
      r  = mkv(v0, v1, v2, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      if (ar == 0) begin
         r.drop = 1; r.lat = 5;
      end else if (ar < 0) begin
`ifdef TRI_SETUP_CULL_EN
         r.drop = 1; r.lat = 5;
`else
         s = -1;
`endif
      end
      if (!r.drop) begin
         r.xmin = x[0]; r.xmax = x[0]; r.ymin = y[0]; r.ymax = y[0];
         for (int i = 1; i < 3; i++) begin
            if (x[i] < r.xmin) r.xmin = x[i];
            if (x[i] > r.xmax) r.xmax = x[i];
            if (y[i] < r.ymin) r.ymin = y[i];
            if (y[i] > r.ymax) r.ymax = y[i];
         end
         if (r.xmin >= 640 || r.ymin >= 480) begin
            r.drop = 1; r.lat = 6;
         end
         if (r.xmax > 639) r.xmax = 639;
         if (r.ymax > 479) r.ymax = 479;
      end
      r.a0 = s * a[0]; r.a1 = s * a[1]; r.a2 = s * a[2];
      r.b0 = s * b[0]; r.b1 = s * b[1]; r.b2 = s * b[2];
      r.c0 = s * c[0]; r.c1 = s * c[1]; r.c2 = s * c[2];
      r.area = s * ar;
      return r;
   endfunction

   function automatic logic [63:0] rvtx();
      int x, y;
      case ($urandom_range(3))
         0: begin x = $urandom_range(65535); y = $urandom_range(65535); end
         1, 2: begin x = $urandom_range(700); y = $urandom_range(520); end
         default: begin x = $urandom_range(3); y = $urandom_range(3); end
      endcase
      return vtx(x, y, $urandom);
   endfunction

   task automatic run_tri(input vec_t e);
      int kv, kt, pulses;
      kv = -1; kt = -1; pulses = 0;
      @(negedge CLK);
      tri_v0 = e.v0; tri_v1 = e.v1; tri_v2 = e.v2; tri_start = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLK);
         tri_start = 1'b0;
         if (k == 1) chk("busy_start", busy, 1);
         if (rs_valid && kv < 0) begin
            kv = k;
            chk("a0", rs_a0, e.a0); chk("a1", rs_a1, e.a1); chk("a2", rs_a2, e.a2);
            chk("b0", rs_b0, e.b0); chk("b1", rs_b1, e.b1); chk("b2", rs_b2, e.b2);
            chk("c0", rs_c0, e.c0); chk("c1", rs_c1, e.c1); chk("c2", rs_c2, e.c2);
            chk("area2", rs_area2, e.area);
            chk("xmin", rs_xmin, e.xmin); chk("xmax", rs_xmax, e.xmax);
            chk("ymin", rs_ymin, e.ymin); chk("ymax", rs_ymax, e.ymax);
            chk("attr0", rs_attr0, e.v0[63:32]);
            chk("attr1", rs_attr1, e.v1[63:32]);
            chk("attr2", rs_attr2, e.v2[63:32]);
         end
         if (vt_ready) begin
            pulses++;
            if (kt < 0) begin
               kt = k;
               chk("busy_at_vt", busy, 1);
            end
         end
         if (kt > 0 && k == kt + 1) chk("busy_after_vt", busy, 0);
      end
      if (e.drop) exp_drops++;
      chk("vt_cycle", kt, e.lat);
      chk("vt_pulses", pulses, 1);
      chk("valid_cycle", kv, e.drop ? -1 : 6);
      chk("drop_cnt", drop_cnt, exp_drops);
   endtask

   initial begin
      int pulses, vals;
      longint snap_c1, snap_area;
      vec_t f;

      rst_n = 1'b0; tri_start = 1'b0; rs_ready = 1'b1;
      tri_v0 = '0; tri_v1 = '0; tri_v2 = '0;
      #3;
      chk("rst_busy", busy, 0);
      chk("rst_valid", rs_valid, 0);
      chk("rst_vt", vt_ready, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_area", rs_area2, 0);
      @(negedge CLK);
      rst_n = 1'b1;

      tbl.push_back(mkv(vtx(0, 0, 32'hA0000001), vtx(10, 0, 32'hA0000002), vtx(0, 10, 32'hA0000003),
                        0, 7, 0, -10, 10, 10, -10, 0, 0, 100, 0, 100, 0, 10, 0, 10));
`ifdef TRI_SETUP_CULL_EN
      tbl.push_back(mkv(vtx(0, 0, 32'hB1), vtx(0, 10, 32'hB2), vtx(10, 0, 32'hB3),
                        1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
`else
      tbl.push_back(mkv(vtx(0, 0, 32'hB1), vtx(0, 10, 32'hB2), vtx(10, 0, 32'hB3),
                        0, 7, 10, -10, 0, 0, -10, 10, 0, 100, 0, 100, 0, 10, 0, 10));
`endif
      tbl.push_back(mkv(vtx(0, 0, 32'hC1), vtx(5, 5, 32'hC2), vtx(10, 10, 32'hC3),
                        1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mkv(vtx(100, 100, 32'hD1), vtx(1000, 100, 32'hD2), vtx(100, 400, 32'hD3),
                        0, 7, 0, -300, 300, 900, -900, 0, -90000, 390000, -30000, 270000,
                        100, 639, 100, 400));
      tbl.push_back(mkv(vtx(700, 0, 32'hE1), vtx(800, 0, 32'hE2), vtx(700, 50, 32'hE3),
                        1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mkv(vtx(639, 479, 32'hF1), vtx(0, 479, 32'hF2), vtx(639, 0, 32'hF3),
                        0, 7, 0, 479, -479, -639, 639, 0, 306081, -306081, 306081, 306081,
                        0, 639, 0, 479));
      tbl.push_back(mkv(vtx(0, 480, 32'h11), vtx(10, 480, 32'h12), vtx(0, 490, 32'h13),
                        1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      foreach (tbl[i]) run_tri(tbl[i]);

      // Backpressure: stall five cycles, a tri_start during the stall must be ignored
      f = tbl[0];
      rs_ready = 1'b0;
      @(negedge CLK);
      tri_v0 = f.v0; tri_v1 = f.v1; tri_v2 = f.v2; tri_start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge CLK);
         tri_start = 1'b0;
      end
      chk("bp_valid", rs_valid, 1);
      snap_c1 = rs_c1; snap_area = rs_area2;
      chk("bp_c1", snap_c1, 100);
      for (int s = 1; s <= 5; s++) begin
         @(negedge CLK);
         tri_start = (s == 2);
         if (s == 2) begin
            tri_v0 = vtx(1, 1, 0); tri_v1 = vtx(30, 1, 0); tri_v2 = vtx(1, 30, 0);
         end
         chk("bp_hold_valid", rs_valid, 1);
         chk("bp_no_vt", vt_ready, 0);
         chk("bp_stable_c1", rs_c1, snap_c1);
         chk("bp_stable_area", rs_area2, snap_area);
      end
      tri_start = 1'b0;
      rs_ready = 1'b1;
      @(negedge CLK);
      chk("bp_vt", vt_ready, 1);
      chk("bp_valid_drop", rs_valid, 0);
      pulses = 0; vals = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         pulses += int'(vt_ready);
         vals += int'(rs_valid);
      end
      chk("bp_ignored_vt", pulses, 0);
      chk("bp_ignored_valid", vals, 0);
      chk("bp_drop_cnt", drop_cnt, exp_drops);

      for (int i = 0; i < 40; i++) run_tri(model(rvtx(), rvtx(), rvtx()));

      // Asynchronous reset while in E1
      @(negedge CLK);
      tri_v0 = f.v0; tri_v1 = f.v1; tri_v2 = f.v2; tri_start = 1'b1;
      @(negedge CLK);
      tri_start = 1'b0;
      @(negedge CLK);
      rst_n = 1'b0;
      #1;
      exp_drops = 0;
      chk("ar_busy", busy, 0);
      chk("ar_valid", rs_valid, 0);
      chk("ar_vt", vt_ready, 0);
      chk("ar_drop", drop_cnt, 0);
      chk("ar_area", rs_area2, 0);
      @(negedge CLK);
      rst_n = 1'b1;
      pulses = 0; vals = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge CLK);
         pulses += int'(vt_ready);
         vals += int'(rs_valid) + int'(busy);
      end
      chk("ar_no_vt", pulses, 0);
      chk("ar_idle", vals, 0);
      run_tri(tbl[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/tri_setup.md
# tri_setup

Triangle setup engine and responder to the draw-triangle command path. It accepts one triangle (three 64-bit vertices) on a `tri_start` pulse and computes three edge-function coefficient sets, the signed doubled area and a screen-clamped bounding box. It presents the result to the rasterizer over a valid/ready handshake, or drops the triangle if it is degenerate, off-screen or (optionally) back-facing. A one-cycle `vt_ready` pulse tells the command engine that the triangle has been consumed.

## Interface
- `DW_VERTEX`, 64, vertex word width; x=[15:0], y=[31:16], attr=[63:32]; x and y are unsigned.
- `SCREEN_W`, 640, screen width in pixels.
- `SCREEN_H`, 480, screen height in pixels.
- `CLK` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `tri_start` in 1: one-cycle request; vertices are valid in the same cycle.
- `tri_v0`, `tri_v1`, `tri_v2` in DW_VERTEX: vertices.
- `vt_ready` out 1: one-cycle pulse when the triangle is emitted or dropped.
- `busy` out 1: high from acceptance until the `vt_ready` cycle, inclusive.
- `rs_valid` out 1: setup result valid.
- `rs_ready` in 1: rasterizer accepts the result.
- `rs_a0..2`, `rs_b0..2` out 17 signed: edge coefficients A and B.
- `rs_c0..2` out 33 signed: edge coefficient C.
- `rs_area2` out 35 signed: doubled area, always ≥1 when `rs_valid` is high.
- `rs_xmin`, `rs_xmax`, `rs_ymin`, `rs_ymax` out 16: clamped bounding box.
- `rs_attr0..2` out 32: vertex attributes, passed through unchanged.
- `drop_cnt` out 16: saturating count of dropped triangles.

## Operation
- Edge i runs from vertex i to vertex (i+1) mod 3.
  - A_i = y_i − y_(i+1)
  - B_i = x_(i+1) − x_i
  - C_i = x_i·y_(i+1) − x_(i+1)·y_i
- Width rules: operands are zero-extended before subtraction. Products are 32-bit unsigned; C is sign-extended to 33 bits; area2 = C0+C1+C2 in 35 bits.
- State machine: IDLE → E0 → E1 → E2 → AREA → BBOX → OUT → IDLE.
  - One edge is computed per cycle using a single multiplier pair.
  - Vertices are latched on acceptance.
- IDLE: `tri_start` is accepted only in IDLE. A `tri_start` while busy is ignored and is not counted.
- AREA:
  - area2 = 0 → drop.
  - area2 < 0 → handled per the Configuration section.
- BBOX: min/max of the three vertices.
  - Drop if xmin ≥ SCREEN_W or ymin ≥ SCREEN_H.
  - Otherwise clamp xmax to SCREEN_W−1 and ymax to SCREEN_H−1.
- OUT: hold `rs_valid` with all `rs_*` outputs stable until `rs_ready` is high.
- Drop path: return to IDLE, pulse `vt_ready`, increment `drop_cnt` (saturates at 0xFFFF).
- Reset: all outputs are 0 and the state is IDLE. Reset asserted mid-operation aborts the triangle with no `vt_ready` pulse.

## Timing
- `tri_start` sampled at cycle N → E0 at N+1, E1 at N+2, E2 at N+3, AREA at N+4, BBOX at N+5.
- `rs_valid` is high from N+6.
- Handshake: `rs_valid` && `rs_ready` in cycle M → `vt_ready` pulses and `rs_valid` drops at M+1. A new `tri_start` is accepted at M+1 or later.
- Area drop decided at N+4 → `vt_ready` at N+5. Off-screen drop decided at N+5 → `vt_ready` at N+6.
- `busy` falls in the cycle after `vt_ready`. The initiator waits for `vt_ready` after pulsing `tri_start`, so `vt_ready` is never asserted in the `tri_start` cycle.
- Minimum triangle period is 7 cycles when `rs_ready` is tied high.

## Configuration
- `TRI_SETUP_CULL_EN`:
  - Defined: area2 < 0 → back-face drop, counted in `drop_cnt`.
  - Undefined: area2 < 0 → all A, B, C and area2 are negated before OUT, so emitted triangles always have positive winding.

## Structure
- Package `tri_pkg` holds:
  - vertex field offsets and widths (X_LSB=0, Y_LSB=16, ATTR_LSB=32);
  - coefficient widths (AB_W=17, C_W=33, AREA_W=35);
  - the state encoding.
- Sub-module `tri_edge_coef`: combinational A/B/C for one edge from two vertices. It is instantiated once and its inputs are multiplexed per state.

## Test plan
- Front-facing: v0=(0,0), v1=(10,0), v2=(0,10), `rs_ready`=1.
  - Expected: A=(0,−10,10), B=(10,−10,0), C=(0,100,0), area2=100, bbox 0..10 both axes.
  - `rs_valid` at N+6, `vt_ready` at N+7.
- Back-facing: same triangle with v1 and v2 swapped.
  - With `TRI_SETUP_CULL_EN`: dropped, `vt_ready` at N+5, `drop_cnt`=1.
  - Without it: area2=100 and coefficients negated.
- Degenerate: (0,0), (5,5), (10,10) → all C=0, area2=0, dropped, `drop_cnt` increments, `rs_valid` never rises.
- Clip and off-screen:
  - (100,100), (1000,100), (100,400) → xmax=639.
  - All x ≥ 700 → dropped at BBOX, `vt_ready` at N+6.
- Backpressure: `rs_ready` low for 5 cycles → `rs_*` stable and no `vt_ready`. After `rs_ready` rises: `vt_ready` one cycle later; a `tri_start` during the stall is ignored.
- Async reset: `rst_n` low during E1 → outputs 0 immediately and IDLE; no `vt_ready`; the next `tri_start` completes normally.
